// File: rtl/mem_compare.sv
// mem_compare: walks an inclusive address range over two synchronous-read memories
// and reports mismatching words under a bit mask.
`default_nettype none

module mem_compare #(
    parameter int A_WIDTH   = 13,
    parameter int D_WIDTH   = 8,
    parameter int CNT_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_go,
    input  logic [A_WIDTH-1:0]   i_start_addr,
    input  logic [A_WIDTH-1:0]   i_end_addr,
    input  logic [D_WIDTH-1:0]   i_mask,
    input  logic                 i_stop_first,
    input  logic [D_WIDTH-1:0]   i_a_in,
    input  logic [D_WIDTH-1:0]   i_b_in,
    output logic [A_WIDTH-1:0]   o_a_addr,
    output logic [A_WIDTH-1:0]   o_b_addr,
    output logic                 o_a_en,
    output logic                 o_b_en,
    output logic                 o_a_rw,
    output logic                 o_b_rw,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error_flag,
    output logic                 o_range_err,
    output logic [CNT_WIDTH-1:0] o_err_count,
    output logic [A_WIDTH-1:0]   o_first_addr,
    output logic [D_WIDTH-1:0]   o_first_a,
    output logic [D_WIDTH-1:0]   o_first_b
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t               r_state;
    logic [A_WIDTH-1:0]   r_addr;
    logic [A_WIDTH-1:0]   r_end;
    logic [D_WIDTH-1:0]   r_mask;
    logic                 r_stop_first;
    logic                 r_vld;
    logic [A_WIDTH-1:0]   r_cmp_addr;
    logic                 r_done;
    logic                 r_error_flag;
    logic                 r_range_err;
    logic [CNT_WIDTH-1:0] r_err_count;
    logic [A_WIDTH-1:0]   r_first_addr;
    logic [D_WIDTH-1:0]   r_first_a;
    logic [D_WIDTH-1:0]   r_first_b;

    logic w_busy;
    logic w_mismatch;

    assign w_busy = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    // Read data is only meaningful while scanning; a read still in flight when
    // the FSM leaves for FIN is dropped here.
    assign w_mismatch = w_busy && r_vld && (((i_a_in ^ i_b_in) & r_mask) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_end        <= '0;
            r_mask       <= '0;
            r_stop_first <= 1'b0;
            r_vld        <= 1'b0;
            r_cmp_addr   <= '0;
            r_done       <= 1'b0;
            r_error_flag <= 1'b0;
            r_range_err  <= 1'b0;
            r_err_count  <= '0;
            r_first_addr <= '0;
            r_first_a    <= '0;
            r_first_b    <= '0;
        end else begin
            r_vld      <= (r_state == S_ISSUE);
            r_cmp_addr <= r_addr;

            if (w_mismatch) begin
                if (!(&r_err_count)) begin
                    r_err_count <= r_err_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
                r_error_flag <= 1'b1;
                if (!r_error_flag) begin
                    r_first_addr <= r_cmp_addr;
                    r_first_a    <= i_a_in;
                    r_first_b    <= i_b_in;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        r_end        <= i_end_addr;
                        r_mask       <= i_mask;
                        r_stop_first <= i_stop_first;
                        r_done       <= 1'b0;
                        r_error_flag <= 1'b0;
                        r_err_count  <= '0;
                        r_first_addr <= '0;
                        r_first_a    <= '0;
                        r_first_b    <= '0;
                        if (i_start_addr > i_end_addr) begin
                            r_range_err <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= S_FIN;
                        end else begin
                            r_range_err <= 1'b0;
                            r_addr      <= i_start_addr;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_mismatch && r_stop_first) begin
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else if (r_addr == r_end) begin
                        // Terminal test precedes the increment so the top address never wraps.
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr <= r_addr + {{(A_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                S_DRAIN: begin
                    r_done  <= 1'b1;
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_a_addr     = r_addr;
    assign o_b_addr     = r_addr;
    assign o_a_en       = (r_state == S_ISSUE);
    assign o_b_en       = (r_state == S_ISSUE);
    assign o_a_rw       = 1'b1;
    assign o_b_rw       = 1'b1;
    assign o_busy       = w_busy;
    assign o_done       = r_done;
    assign o_error_flag = r_error_flag;
    assign o_range_err  = r_range_err;
    assign o_err_count  = r_err_count;
    assign o_first_addr = r_first_addr;
    assign o_first_a    = r_first_a;
    assign o_first_b    = r_first_b;

endmodule

`default_nettype wire

// File: tb/tb_mem_compare.sv
// tb_mem_compare: directed bench for mem_compare with two synchronous-read memory models.
`default_nettype none

module tb_mem_compare;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int CW = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [DW-1:0] mask = 8'hFF;
    logic          stop_first = 1'b0;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic [AW-1:0] a_addr, b_addr, first_addr;
    logic          a_en, b_en, a_rw, b_rw, busy, done, err_flag, range_err;
    logic [CW-1:0] err_count;
    logic [DW-1:0] first_a, first_b;

    logic [DW-1:0] mem_a [0:8191];
    logic [DW-1:0] mem_b [0:8191];

    int n_checks = 0;
    int n_fail = 0;
    int cycle_cnt = 0;
    int t0 = 0;
    int reads = 0;
    int port_diff = 0;
    int cyc;

    mem_compare #(.A_WIDTH(AW), .D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_go(go),
        .i_start_addr(start_addr), .i_end_addr(end_addr),
        .i_mask(mask), .i_stop_first(stop_first),
        .i_a_in(a_in), .i_b_in(b_in),
        .o_a_addr(a_addr), .o_b_addr(b_addr),
        .o_a_en(a_en), .o_b_en(b_en), .o_a_rw(a_rw), .o_b_rw(b_rw),
        .o_busy(busy), .o_done(done), .o_error_flag(err_flag),
        .o_range_err(range_err), .o_err_count(err_count),
        .o_first_addr(first_addr), .o_first_a(first_a), .o_first_b(first_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_en) a_in <= mem_a[a_addr];
        if (b_en) b_in <= mem_b[b_addr];
    end

    always @(posedge clk) begin
        cycle_cnt++;
        if (a_en === 1'b1) reads++;
        if (a_addr !== b_addr || a_en !== b_en) port_diff++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_go(input logic [AW-1:0] s, input logic [AW-1:0] e,
                            input logic [DW-1:0] m, input logic sf);
        @(negedge clk);
        start_addr = s;
        end_addr   = e;
        mask       = m;
        stop_first = sf;
        go         = 1'b1;
        reads      = 0;
        @(negedge clk);
        go = 1'b0;
        t0 = cycle_cnt;
    endtask

    task automatic wait_done(output int c);
        int k = 0;
        while (done !== 1'b1 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
        c = cycle_cnt - t0;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem_a[i] = DW'(i) ^ 8'h5A;
            mem_b[i] = DW'(i) ^ 8'h5A;
        end

        // Reset state
        #12;
        check("rst0_addr", {6'd0, a_addr, b_addr}, 32'd0);
        check("rst0_flags", {a_en, b_en, busy, done, err_flag, range_err}, 32'd0);
        check("rst0_cnt", err_count, 32'd0);
        check("rst0_first", {first_addr, first_a, first_b}, 32'd0);
        check("rst0_rw", {a_rw, b_rw}, 32'd3);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-range identical scan
        start_go(13'd0, 13'd8191, 8'hFF, 1'b0);
        wait_done(cyc);
        check("full_cycles", cyc, 32'd8193);
        check("full_reads", reads, 32'd8192);
        check("full_errflag", err_flag, 32'd0);
        check("full_cnt", err_count, 32'd0);
        check("full_range", range_err, 32'd0);
        repeat (5) @(negedge clk);
        check("full_done_hold", {done, busy, a_en}, 32'b100);

        // Two mismatches; a Go while busy must be ignored
        mem_a[16'h010] = 8'h3C; mem_b[16'h010] = 8'h3D;
        mem_a[16'h200] = 8'h55; mem_b[16'h200] = 8'hAA;
        start_go(13'd0, 13'h3FF, 8'hFF, 1'b0);
        repeat (10) @(negedge clk);
        start_addr = 13'd5; end_addr = 13'd6; mask = 8'h00; stop_first = 1'b1; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done(cyc);
        check("two_cycles", cyc, 32'd1025);
        check("two_cnt", err_count, 32'd2);
        check("two_flag", err_flag, 32'd1);
        check("two_first_addr", first_addr, 32'h010);
        check("two_first_a", first_a, 32'h3C);
        check("two_first_b", first_b, 32'h3D);

        // Same data, bit 0 masked out
        start_go(13'd0, 13'h3FF, 8'hFE, 1'b0);
        wait_done(cyc);
        check("mask_cnt", err_count, 32'd1);
        check("mask_first_addr", first_addr, 32'h200);
        check("mask_first_ab", {first_a, first_b}, 32'h55AA);

        // Stop at first mismatch
        mem_b[5] = mem_a[5] ^ 8'h80;
        mem_b[6] = mem_a[6] ^ 8'h01;
        start_go(13'd0, 13'h3FF, 8'hFF, 1'b1);
        wait_done(cyc);
        check("stop_cycles", cyc, 32'd7);
        check("stop_reads", reads, 32'd7);
        check("stop_cnt", err_count, 32'd1);
        check("stop_first_addr", first_addr, 32'h005);
        check("stop_first_ab", {first_a, first_b}, {16'd0, 8'h5F, 8'hDF});
        repeat (3) @(negedge clk);
        check("stop_cnt_hold", err_count, 32'd1);

        // Reversed range
        start_go(13'h100, 13'h0FF, 8'hFF, 1'b0);
        wait_done(cyc);
        check("range_latency", (cyc < 2) ? 32'd1 : 32'd0, 32'd1);
        check("range_flags", {done, range_err, err_flag}, 32'b110);
        repeat (3) @(negedge clk);
        check("range_reads", reads, 32'd0);
        check("range_cnt", err_count, 32'd0);

        // Asynchronous reset mid-scan at address 0x80
        start_go(13'd0, 13'h3FF, 8'hFF, 1'b0);
        begin
            int k = 0;
            while (!(a_addr === 13'h080 && a_en === 1'b1) && k < 2000) begin
                @(negedge clk);
                k++;
            end
        end
        check("pre_rst_addr", a_addr, 32'h080);
        check("pre_rst_cnt", err_count, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("arst_addr", {6'd0, a_addr, b_addr}, 32'd0);
        check("arst_flags", {a_en, b_en, busy, done, err_flag, range_err}, 32'd0);
        check("arst_cnt", err_count, 32'd0);
        check("arst_first", {first_addr, first_a, first_b}, 32'd0);
        check("arst_rw", {a_rw, b_rw}, 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", {done, busy, a_en}, 32'd0);

        start_go(13'h300, 13'h30F, 8'hFF, 1'b0);
        wait_done(cyc);
        check("clean_cycles", cyc, 32'd17);
        check("clean_reads", reads, 32'd16);
        check("clean_cnt", {err_flag, 18'd0, err_count}, 32'd0);

        check("port_match", port_diff, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_compare.md
MEM_COMPARE -- requirements
Module: mem_compare

Interface
REQ-001 Parameter A_WIDTH, default 13, address width of both compared memories.
REQ-002 Parameter D_WIDTH, default 8, data word width.
REQ-003 Parameter CNT_WIDTH, default 14, mismatch counter width.
REQ-004 Clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Rst  input  1  asynchronous, active-low reset.
REQ-006 Go  input  1  start request, sampled on rising edge.
REQ-007 Start_Addr, End_Addr  input  A_WIDTH  inclusive compare range, sampled when Go is accepted.
REQ-008 Mask  input  D_WIDTH  bit=1 includes that data bit in the compare; sampled when Go is accepted.
REQ-009 Stop_First  input  1  mode: 1 halts at first mismatch, 0 scans the whole range; sampled when Go is accepted.
REQ-010 A_In, B_In  input  D_WIDTH  read data from memories A and B.
REQ-011 A_Addr, B_Addr  output  A_WIDTH  read address, identical on both ports.
REQ-012 A_En, B_En  output  1  memory enable; A_Rw, B_Rw  output  1  fixed 1 (read), never 0.
REQ-013 Busy, Done, Error_Flag, Range_Err  output  1  status.
REQ-014 Err_Count  output  CNT_WIDTH  number of mismatching words.
REQ-015 First_Addr  output  A_WIDTH; First_A, First_B  output  D_WIDTH  address and data of first mismatch.

Function
REQ-016 The block SHALL assume synchronous-read SRAM: address and En driven in cycle k yield valid data on A_In/B_In in cycle k+1.
REQ-017 FSM states SHALL be IDLE, ISSUE, DRAIN and FIN.
REQ-018 IDLE: Go=1 -> capture inputs, clear Done/Error_Flag/Range_Err/Err_Count/First_*, go to ISSUE; if Start_Addr>End_Addr, go to FIN with Range_Err=1 and issue no reads.
REQ-019 ISSUE SHALL drive En=1 and one new address per cycle, Start_Addr up to End_Addr, ascending.
REQ-020 Compare of address n SHALL occur one cycle after its issue: mismatch when ((A_In^B_In)&Mask)!=0.
REQ-021 After End_Addr is issued, the FSM SHALL go to DRAIN for exactly one cycle to compare the last word, then go to FIN.
REQ-022 The address counter SHALL detect End_Addr before incrementing; End_Addr=2^A_WIDTH-1 SHALL NOT wrap or cause extra reads.
REQ-023 On each mismatch, Err_Count SHALL increment and saturate at 2^CNT_WIDTH-1; Error_Flag SHALL set.
REQ-024 On the first mismatch only, First_Addr/First_A/First_B SHALL capture the address and unmasked raw data.
REQ-025 If Stop_First=1, a mismatch SHALL cause FIN on the next edge; the in-flight read result SHALL be discarded, and Err_Count SHALL equal 1.
REQ-026 FIN SHALL assert Done=1 and return to IDLE in the same cycle; Done and all results SHALL hold until the next accepted Go.
REQ-027 Busy SHALL be 1 in ISSUE and DRAIN, 0 otherwise; En SHALL be 0 outside ISSUE.
REQ-028 Go while Busy=1 SHALL be ignored.
REQ-029 A full-range scan of N words SHALL take N+1 cycles from Go acceptance to Done.

Reset
REQ-030 Rst=0 SHALL immediately force IDLE and set every output to 0, including En and Done, with A_Rw/B_Rw=1.
REQ-031 Reset mid-scan SHALL abort with no Done pulse, and results SHALL be cleared.

Verification
REQ-032 A=B identical over 0..8191, Mask=FF, Stop_First=0 -> Done after 8193 cycles, Error_Flag=0, Err_Count=0, no address above 8191.
REQ-033 B differs at 0x010 (A=0x3C, B=0x3D) and 0x200 -> Err_Count=2, First_Addr=0x010, First_A=0x3C, First_B=0x3D.
REQ-034 Same data with Mask=FE -> 0x010 difference ignored; Err_Count=1, First_Addr=0x200.
REQ-035 Stop_First=1 with mismatches at 0x005 and 0x006 -> Done after 0x006 is issued, Err_Count=1, First_Addr=0x005.
REQ-036 Start_Addr=0x100, End_Addr=0x0FF -> Range_Err=1, Done=1 two cycles after Go, En never asserted.
REQ-037 Rst=0 pulse at address 0x80 of a scan -> all outputs 0 asynchronously; a new Go then runs a clean scan.
